// File: rtl/titan_prefetch_unit.sv
// Instruction prefetcher: runs Wishbone classic reads ahead of IF and keeps up to DEPTH
// entries, each tagged with its PC and fault flags. A redirect flushes the queue.
module titan_prefetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  input  logic                     deq_ready_i,
  output logic                     out_valid_o,
  output logic [31:0]              out_pc_o,
  output logic [31:0]              out_instr_o,
  output logic                     out_access_fault_o,
  output logic                     out_misaligned_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [31:0]              iwbm_addr_o,
  output logic                     iwbm_cyc_o,
  output logic                     iwbm_stb_o,
  input  logic [31:0]              iwbm_dat_i,
  input  logic                     iwbm_ack_i,
  input  logic                     iwbm_err_i
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_e;

  state_e          state_q, state_d;
  logic            halted_q, halted_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d, count_after;

  logic [31:0]     pc_mem_q    [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];
  logic            af_mem_q    [DEPTH];
  logic            mis_mem_q   [DEPTH];

  logic            pop, push, flush, resp, redir_mis;
  logic [PW-1:0]   wr_idx;
  logic [31:0]     wr_pc, wr_instr;
  logic            wr_af, wr_mis;

  assign out_valid_o = (count_q != '0);
  assign pop         = out_valid_o & deq_ready_i;
  assign resp        = iwbm_ack_i | iwbm_err_i;
  assign redir_mis   = (redirect_pc_i[1:0] != 2'b00);
  assign count_after = count_q + CW'(1) - CW'(pop);

  always_comb begin
    state_d    = state_q;
    halted_d   = halted_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    wr_idx     = tail_q;
    wr_pc      = fetch_pc_q;
    wr_instr   = '0;
    wr_af      = 1'b0;
    wr_mis     = 1'b0;

    case (state_q)
      IDLE: begin
        // A pop while full frees a slot at this edge, so fetching may resume immediately.
        if (!halted_q && ((count_q != FULL) || pop)) state_d = FETCH;
      end
      FETCH: begin
        if (iwbm_err_i) begin
          push     = 1'b1;
          wr_af    = 1'b1;
          halted_d = 1'b1;
          state_d  = IDLE;
        end else if (iwbm_ack_i) begin
          push       = 1'b1;
          wr_instr   = iwbm_dat_i;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = (count_after < FULL) ? FETCH : IDLE;
        end
      end
      DRAIN: begin
        if (resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything: any response this cycle is dropped with the queue.
    if (redirect_i) begin
      flush      = 1'b1;
      fetch_pc_d = redirect_pc_i;
      halted_d   = redir_mis;
      push       = redir_mis;
      wr_idx     = '0;
      wr_pc      = redirect_pc_i;
      wr_instr   = '0;
      wr_af      = 1'b0;
      wr_mis     = redir_mis;
      case (state_q)
        FETCH, DRAIN: state_d = resp ? IDLE : DRAIN;
        default:      state_d = redir_mis ? IDLE : FETCH;
      endcase
    end

    head_d  = flush ? '0 : head_q + PW'(pop);
    tail_d  = flush ? PW'(push) : tail_q + PW'(push);
    count_d = flush ? CW'(push) : count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      halted_q   <= 1'b0;
      fetch_pc_q <= RESET_ADDR;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem_q[wr_idx]    <= wr_pc;
      instr_mem_q[wr_idx] <= wr_instr;
      af_mem_q[wr_idx]    <= wr_af;
      mis_mem_q[wr_idx]   <= wr_mis;
    end
  end

  assign out_pc_o           = out_valid_o ? pc_mem_q[head_q] : '0;
  assign out_access_fault_o = out_valid_o & af_mem_q[head_q];
  assign out_misaligned_o   = out_valid_o & mis_mem_q[head_q];
  assign out_instr_o        = (out_valid_o && !af_mem_q[head_q] && !mis_mem_q[head_q])
                              ? instr_mem_q[head_q] : '0;
  assign count_o            = count_q;
  assign iwbm_addr_o        = fetch_pc_q;
  assign iwbm_cyc_o         = (state_q == FETCH) || (state_q == DRAIN);
  assign iwbm_stb_o         = (state_q == FETCH) || (state_q == DRAIN);
endmodule

// File: tb/tb_titan_prefetch_unit.sv
// Scoreboard bench for titan_prefetch_unit: a Wishbone slave stub answers in the same
// cycle, expected queue entries are pushed as responses are driven and popped on dequeue.
module tb_titan_prefetch_unit;
  typedef logic [65:0] ent_t;  // {pc, instr, access_fault, misaligned}

  localparam logic [31:0] NOERR = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        deq_ready_i;
  logic        out_valid_o;
  logic [31:0] out_pc_o;
  logic [31:0] out_instr_o;
  logic        out_access_fault_o;
  logic        out_misaligned_o;
  logic [2:0]  count_o;
  logic [31:0] iwbm_addr_o;
  logic        iwbm_cyc_o;
  logic        iwbm_stb_o;
  logic [31:0] iwbm_dat_i;
  logic        iwbm_ack_i;
  logic        iwbm_err_i;

  int          errors;
  int          checks;
  int          acks_given;
  logic [31:0] last_ack_addr;
  ent_t        sb[$];
  ent_t        e;

  titan_prefetch_unit #(.RESET_ADDR(32'h0000_0100), .DEPTH(4)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .redirect_i         (redirect_i),
    .redirect_pc_i      (redirect_pc_i),
    .deq_ready_i        (deq_ready_i),
    .out_valid_o        (out_valid_o),
    .out_pc_o           (out_pc_o),
    .out_instr_o        (out_instr_o),
    .out_access_fault_o (out_access_fault_o),
    .out_misaligned_o   (out_misaligned_o),
    .count_o            (count_o),
    .iwbm_addr_o        (iwbm_addr_o),
    .iwbm_cyc_o         (iwbm_cyc_o),
    .iwbm_stb_o         (iwbm_stb_o),
    .iwbm_dat_i         (iwbm_dat_i),
    .iwbm_ack_i         (iwbm_ack_i),
    .iwbm_err_i         (iwbm_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // One clock: drive inputs just after the rising edge, return at the falling edge.
  // Responses the bench does not expect to be enqueued carry junk data.
  task automatic bus_cycle(input logic dq, input logic ack, input logic [31:0] err_at,
                           input logic exp, input logic redir, input logic [31:0] rpc);
    @(posedge clk); #1;
    deq_ready_i   = dq;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    iwbm_ack_i    = 1'b0;
    iwbm_err_i    = 1'b0;
    iwbm_dat_i    = 32'h0;
    if (redir) begin
      sb.delete();
      if (rpc[1:0] != 2'b00) sb.push_back({rpc, 32'h0, 1'b0, 1'b1});
    end
    if (iwbm_cyc_o && iwbm_stb_o) begin
      if (iwbm_addr_o == err_at) begin
        iwbm_err_i = 1'b1;
        iwbm_dat_i = 32'hBAD0_BAD0;
        if (exp) sb.push_back({iwbm_addr_o, 32'h0, 1'b1, 1'b0});
      end else if (ack) begin
        iwbm_ack_i    = 1'b1;
        iwbm_dat_i    = exp ? mem_word(iwbm_addr_o) : 32'hBAD0_BAD0;
        acks_given++;
        last_ack_addr = iwbm_addr_o;
        if (exp) sb.push_back({iwbm_addr_o, mem_word(iwbm_addr_o), 1'b0, 1'b0});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0; deq_ready_i = 1'b0;
    iwbm_dat_i = 32'h0; iwbm_ack_i = 1'b0; iwbm_err_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid_o !== 1'b0 || count_o !== 3'd0 || out_pc_o !== 32'h0 || out_instr_o !== 32'h0) begin
      errors++; $display("FAIL reset_queue valid=%b count=%0d pc=%h instr=%h, want 0", out_valid_o, count_o, out_pc_o, out_instr_o);
    end
    checks++;
    if (iwbm_cyc_o !== 1'b0 || iwbm_stb_o !== 1'b0 || iwbm_addr_o !== 32'h100) begin
      errors++; $display("FAIL reset_bus cyc=%b stb=%b addr=%h, want 0 0 00000100", iwbm_cyc_o, iwbm_stb_o, iwbm_addr_o);
    end
    checks++;
    if (out_access_fault_o !== 1'b0 || out_misaligned_o !== 1'b0) begin
      errors++; $display("FAIL reset_flags af=%b mis=%b, want 0 0", out_access_fault_o, out_misaligned_o);
    end
    rst_i = 1'b1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 13; i++) begin
      bus_cycle(1'b1, i < 10, NOERR, 1'b1, 1'b0, 32'h0);
      checks++;
      if (count_o > 3'd1) begin errors++; $display("FAIL stream_count got=%0d want<=1", count_o); end
      if (out_valid_o && deq_ready_i) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL stream_head extra entry pc=%h", out_pc_o); end
        else begin
          e = sb.pop_front();
          if ({out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o} !== e) begin
            errors++; $display("FAIL stream_head got=%h want=%h", {out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o}, e);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL stream_drain left=%0d want 0", sb.size()); end
  endtask

  task automatic test_redirect_with_ack();
    bus_cycle(1'b0, 1'b1, NOERR, 1'b0, 1'b1, 32'h2000);
    bus_cycle(1'b1, 1'b0, NOERR, 1'b0, 1'b0, 32'h0);
    checks++;
    if (count_o !== 3'd0 || out_valid_o !== 1'b0 || iwbm_cyc_o !== 1'b0) begin
      errors++; $display("FAIL redir_ack_flush count=%0d valid=%b cyc=%b, want 0 0 0", count_o, out_valid_o, iwbm_cyc_o);
    end
    for (int i = 0; i < 10; i++) begin
      bus_cycle(1'b1, i < 7, NOERR, 1'b1, 1'b0, 32'h0);
      if (out_valid_o && deq_ready_i) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL redir_ack_head extra entry pc=%h", out_pc_o); end
        else begin
          e = sb.pop_front();
          if ({out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o} !== e) begin
            errors++; $display("FAIL redir_ack_head got=%h want=%h", {out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o}, e);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL redir_ack_drain left=%0d want 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    bus_cycle(1'b0, 1'b1, NOERR, 1'b0, 1'b1, 32'h1000);
    acks_given = 0;
    for (int i = 0; i < 8; i++) bus_cycle(1'b0, 1'b1, NOERR, 1'b1, 1'b0, 32'h0);
    checks++;
    if (acks_given != 4 || count_o !== 3'd4 || iwbm_cyc_o !== 1'b0) begin
      errors++; $display("FAIL bp_full acks=%0d count=%0d cyc=%b, want 4 4 0", acks_given, count_o, iwbm_cyc_o);
    end
    bus_cycle(1'b1, 1'b1, NOERR, 1'b1, 1'b0, 32'h0);
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL bp_pop no expected entry, got pc=%h", out_pc_o); end
    else begin
      e = sb.pop_front();
      if ({out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o} !== e) begin
        errors++; $display("FAIL bp_pop got=%h want=%h", {out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o}, e);
      end
    end
    acks_given = 0;
    for (int i = 0; i < 4; i++) bus_cycle(1'b0, 1'b1, NOERR, 1'b1, 1'b0, 32'h0);
    checks++;
    if (acks_given != 1 || last_ack_addr !== 32'h1010 || count_o !== 3'd4) begin
      errors++; $display("FAIL bp_refill acks=%0d addr=%h count=%0d, want 1 00001010 4", acks_given, last_ack_addr, count_o);
    end
    for (int i = 0; i < 6; i++) begin
      bus_cycle(1'b1, 1'b0, NOERR, 1'b0, 1'b0, 32'h0);
      if (out_valid_o && deq_ready_i) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL bp_head extra entry pc=%h", out_pc_o); end
        else begin
          e = sb.pop_front();
          if ({out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o} !== e) begin
            errors++; $display("FAIL bp_head got=%h want=%h", {out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o}, e);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL bp_drain left=%0d want 0", sb.size()); end
  endtask

  task automatic test_redirect_mid();
    bus_cycle(1'b1, 1'b0, NOERR, 1'b0, 1'b1, 32'h2000);
    for (int i = 0; i < 2; i++) begin
      bus_cycle(1'b1, 1'b0, NOERR, 1'b0, 1'b0, 32'h0);
      checks++;
      if (count_o !== 3'd0 || out_valid_o !== 1'b0 || iwbm_cyc_o !== 1'b1) begin
        errors++; $display("FAIL drain_state count=%0d valid=%b cyc=%b, want 0 0 1", count_o, out_valid_o, iwbm_cyc_o);
      end
    end
    bus_cycle(1'b1, 1'b1, NOERR, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 11; i++) begin
      bus_cycle(1'b1, i < 8, NOERR, 1'b1, 1'b0, 32'h0);
      if (out_valid_o && deq_ready_i) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL mid_head extra entry pc=%h", out_pc_o); end
        else begin
          e = sb.pop_front();
          if ({out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o} !== e) begin
            errors++; $display("FAIL mid_head got=%h want=%h", {out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o}, e);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL mid_drain left=%0d want 0", sb.size()); end
  endtask

  task automatic test_faults();
    bus_cycle(1'b0, 1'b1, NOERR, 1'b0, 1'b1, 32'h100);
    for (int i = 0; i < 12; i++) begin
      bus_cycle(1'b1, 1'b1, 32'h108, 1'b1, 1'b0, 32'h0);
      if (i >= 8) begin
        checks++;
        if (iwbm_cyc_o !== 1'b0) begin errors++; $display("FAIL fault_halt cyc=%b want 0", iwbm_cyc_o); end
      end
      if (out_valid_o && deq_ready_i) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL fault_head extra entry pc=%h", out_pc_o); end
        else begin
          e = sb.pop_front();
          if ({out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o} !== e) begin
            errors++; $display("FAIL fault_head got=%h want=%h", {out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o}, e);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL fault_drain left=%0d want 0", sb.size()); end

    bus_cycle(1'b0, 1'b0, NOERR, 1'b0, 1'b1, 32'h302);
    for (int i = 0; i < 2; i++) begin
      bus_cycle(1'b0, 1'b1, NOERR, 1'b1, 1'b0, 32'h0);
      checks++;
      if (count_o !== 3'd1 || iwbm_cyc_o !== 1'b0 || out_misaligned_o !== 1'b1) begin
        errors++; $display("FAIL misalign_entry count=%0d cyc=%b mis=%b, want 1 0 1", count_o, iwbm_cyc_o, out_misaligned_o);
      end
    end
    bus_cycle(1'b1, 1'b1, NOERR, 1'b1, 1'b0, 32'h0);
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL misalign_head no expected entry, got pc=%h", out_pc_o); end
    else begin
      e = sb.pop_front();
      if ({out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o} !== e) begin
        errors++; $display("FAIL misalign_head got=%h want=%h", {out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o}, e);
      end
    end
    for (int i = 0; i < 2; i++) begin
      bus_cycle(1'b1, 1'b1, NOERR, 1'b1, 1'b0, 32'h0);
      checks++;
      if (count_o !== 3'd0 || iwbm_cyc_o !== 1'b0) begin
        errors++; $display("FAIL misalign_nobus count=%0d cyc=%b, want 0 0", count_o, iwbm_cyc_o);
      end
    end

    bus_cycle(1'b0, 1'b0, NOERR, 1'b0, 1'b1, 32'h300);
    for (int i = 0; i < 10; i++) begin
      bus_cycle(1'b1, i < 7, NOERR, 1'b1, 1'b0, 32'h0);
      if (out_valid_o && deq_ready_i) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL resume_head extra entry pc=%h", out_pc_o); end
        else begin
          e = sb.pop_front();
          if ({out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o} !== e) begin
            errors++; $display("FAIL resume_head got=%h want=%h", {out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o}, e);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0 || acks_given == 0) begin
      errors++; $display("FAIL resume_drain left=%0d acks=%0d, want 0 and >0", sb.size(), acks_given);
    end
  endtask

  task automatic test_async_reset();
    bus_cycle(1'b0, 1'b1, NOERR, 1'b0, 1'b1, 32'h500);
    acks_given = 0;
    for (int i = 0; i < 10 && acks_given < 3; i++) bus_cycle(1'b0, 1'b1, NOERR, 1'b1, 1'b0, 32'h0);
    bus_cycle(1'b0, 1'b0, NOERR, 1'b0, 1'b0, 32'h0);
    checks++;
    if (count_o !== 3'd3 || iwbm_cyc_o !== 1'b1) begin
      errors++; $display("FAIL areset_setup count=%0d cyc=%b, want 3 1", count_o, iwbm_cyc_o);
    end
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || count_o !== 3'd0 || iwbm_cyc_o !== 1'b0 || iwbm_stb_o !== 1'b0
        || iwbm_addr_o !== 32'h100 || out_pc_o !== 32'h0) begin
      errors++; $display("FAIL areset_clear valid=%b count=%0d cyc=%b stb=%b addr=%h pc=%h, want 0 0 0 0 00000100 0",
                         out_valid_o, count_o, iwbm_cyc_o, iwbm_stb_o, iwbm_addr_o, out_pc_o);
    end
    sb.delete();
    @(negedge clk);
    rst_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus_cycle(1'b1, i < 6, NOERR, 1'b1, 1'b0, 32'h0);
      if (out_valid_o && deq_ready_i) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL areset_head extra entry pc=%h", out_pc_o); end
        else begin
          e = sb.pop_front();
          if ({out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o} !== e || e[65:34] === 32'h0) begin
            errors++; $display("FAIL areset_head got=%h want=%h", {out_pc_o, out_instr_o, out_access_fault_o, out_misaligned_o}, e);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL areset_drain left=%0d want 0", sb.size()); end
  endtask

  initial begin
    errors = 0; checks = 0; acks_given = 0; last_ack_addr = 32'h0;
    test_reset();
    test_stream();
    test_redirect_with_ack();
    test_backpressure();
    test_redirect_mid();
    test_faults();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
